prbs_seq_ctrl: RTL and testbench

PRBS_SEQ_CTRL -- requirements
Module: prbs_seq_ctrl

---
 rtl/prbs_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_prbs_seq_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_seq_ctrl.sv
// Sequencer for a detect-then-generate PRBS-15 run: clears the pattern detector, waits for a
// detection, loads the LFSR seed, then enables it for a latched number of bits.
// Optional macro PRBS_SEQ_CTRL_TIMEOUT_EN adds a WAIT_DET timeout that ends in the ERR state.
module prbs_seq_ctrl #(
    parameter logic [14:0] SEED    = 15'h7FFF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [2:0]  n_cfg_i,
    input  logic [15:0] prbs_len_i,
    input  logic        det_flag_i,
    output logic        det_rst_o,
    output logic [2:0]  det_n_o,
    output logic        prbs_load_o,
    output logic [14:0] prbs_seed_o,
    output logic        prbs_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitDet,
        StSeed,
        StRun,
        StDone,
        StErr
    } state_e;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : gen_bad_timeout
        $error("prbs_seq_ctrl: TIMEOUT must be within 1..65535");
    end

    state_e      state_q, state_d;
    logic [2:0]  det_n_q, det_n_d;
    logic [15:0] len_q, len_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic        wait_expired;

`ifdef PRBS_SEQ_CTRL_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Counts completed WAIT_DET cycles; restarts from zero on every entry.
    assign wait_expired = (wait_cnt_q == TmoLast);
    assign wait_cnt_d   = (state_q == StWaitDet) ? wait_cnt_q + 16'd1 : 16'd0;

    always_comb begin
        timeout_err_d = timeout_err_q;
        if (state_q == StIdle && start_i) begin
            timeout_err_d = 1'b0;
        end
        if (state_d == StErr) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign wait_expired  = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        det_n_d   = det_n_q;
        len_d     = len_q;
        run_cnt_d = run_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    det_n_d = n_cfg_i;
                    len_d   = prbs_len_i;
                    state_d = StArm;
                end
            end
            StArm: begin
                state_d = StWaitDet;
            end
            StWaitDet: begin
                // A detection on the expiry cycle still proceeds to SEED.
                if (det_flag_i) begin
                    state_d = StSeed;
                end else if (wait_expired) begin
                    state_d = StErr;
                end
            end
            StSeed: begin
                run_cnt_d = len_q;
                state_d   = (len_q != 16'd0) ? StRun : StDone;
            end
            StRun: begin
                run_cnt_d = run_cnt_q - 16'd1;
                if (run_cnt_q == 16'd1) begin
                    state_d = StDone;
                end
            end
            StDone, StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_i && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            det_n_q   <= 3'd0;
            len_q     <= 16'd0;
            run_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            det_n_q   <= det_n_d;
            len_q     <= len_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign det_rst_o   = (state_q == StArm);
    assign det_n_o     = det_n_q;
    assign prbs_load_o = (state_q == StSeed);
    assign prbs_seed_o = SEED;
    assign prbs_en_o   = (state_q == StRun);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl: a timeline model predicts every output each cycle,
// and per-scenario pulse counts and latencies are pinned to hand-computed literals.
module tb_prbs_seq_ctrl;

    localparam int unsigned TMO = 16;

    localparam int PIdle = 0;
    localparam int PArm  = 1;
    localparam int PWait = 2;
    localparam int PSeed = 3;
    localparam int PRun  = 4;
    localparam int PDone = 5;
    localparam int PErr  = 6;

    logic        clk = 1'b0;
    logic        rst, start, abort, det_flag;
    logic [2:0]  n_cfg;
    logic [15:0] prbs_len;
    logic        det_rst, prbs_load, prbs_en, busy, done, timeout_err;
    logic [2:0]  det_n;
    logic [14:0] prbs_seed;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    prbs_seq_ctrl #(
        .SEED    (15'h7FFF),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .abort_i       (abort),
        .n_cfg_i       (n_cfg),
        .prbs_len_i    (prbs_len),
        .det_flag_i    (det_flag),
        .det_rst_o     (det_rst),
        .det_n_o       (det_n),
        .prbs_load_o   (prbs_load),
        .prbs_seed_o   (prbs_seed),
        .prbs_en_o     (prbs_en),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_err_o (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: a sequence is the accept cycle t0, the detection cycle m and length L.
    int       cyc = 0;
    bit       act = 1'b0;
    int       t0, m, len;
    int       mn = 0;
    bit       terr = 1'b0;
    bit       chk_on = 1'b0;

    function automatic int phase_at(input int j);
        if (j == t0 + 1) return PArm;
        if (m < 0) begin
`ifdef PRBS_SEQ_CTRL_TIMEOUT_EN
            if (j == t0 + 2 + int'(TMO)) return PErr;
            if (j > t0 + 2 + int'(TMO)) return PIdle;
`endif
            return PWait;
        end
        if (j <= m) return PWait;
        if (j == m + 1) return PSeed;
        if (j <= m + 1 + len) return PRun;
        if (j == m + 2 + len) return PDone;
        return PIdle;
    endfunction

    initial forever begin
        int k, p;
        @(posedge clk);
        k = cyc + 1;
        if (rst) begin
            act  = 1'b0;
            terr = 1'b0;
            mn   = 0;
        end else if (act) begin
            p = phase_at(k - 1);
            if (abort || p == PDone || p == PErr) begin
                act = 1'b0;
            end else if (p == PWait && det_flag) begin
                m = k - 1;
            end
            if (act && phase_at(k) == PErr) terr = 1'b1;
        end else if (start) begin
            act  = 1'b1;
            t0   = k - 1;
            m    = -1;
            len  = int'(prbs_len);
            mn   = int'(n_cfg);
            terr = 1'b0;
        end
        cyc = k;
    end

    int en_cnt, done_cnt, load_cnt, drst_cnt;
    int first_en_cyc, load_cyc, done_cyc;

    initial forever begin
        int p;
        @(negedge clk);
        if (chk_on) begin
            p = act ? phase_at(cyc) : PIdle;
            check("busy", 32'(busy), 32'(p != PIdle));
            check("det_rst", 32'(det_rst), 32'(p == PArm));
            check("prbs_load", 32'(prbs_load), 32'(p == PSeed));
            check("prbs_en", 32'(prbs_en), 32'(p == PRun));
            check("done", 32'(done), 32'(p == PDone));
            check("det_n", 32'(det_n), 32'(mn));
            check("timeout_err", 32'(timeout_err), 32'(terr));
        end
        if (prbs_en === 1'b1) begin
            en_cnt++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prbs_load === 1'b1) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (det_rst === 1'b1) drst_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        en_cnt = 0; done_cnt = 0; load_cnt = 0; drst_cnt = 0;
        first_en_cyc = -1; load_cyc = -1; done_cyc = -1;
    endtask

    // Returns in the ARM cycle of the newly accepted sequence.
    task automatic go(input logic [2:0] n, input logic [15:0] l);
        start = 1'b1; n_cfg = n; prbs_len = l;
        tick();
        start = 1'b0;
    endtask

    int m_cyc;

    task automatic pulse_det();
        det_flag = 1'b1;
        m_cyc = cyc;
        tick();
        det_flag = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        for (int i = 0; i < max && busy !== 1'b0; i++) tick();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy still %0d after %0d cycles, expected 0", name, busy, max);
        end
    endtask

    task automatic wait_en(input string name, input int max);
        for (int i = 0; i < max && prbs_en !== 1'b1; i++) tick();
        vectors++;
        if (prbs_en !== 1'b1) begin
            errors++;
            $display("FAIL %s: prbs_en still %0d after %0d cycles, expected 1", name, prbs_en, max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; det_flag = 1'b0;
        n_cfg = 3'd0; prbs_len = 16'd0;
        clr_cnt();
        tick();
        chk_on = 1'b1;
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_det_n", 32'(det_n), 32'd0);
        check("reset_en", 32'(prbs_en), 32'd0);
        check("seed", 32'(prbs_seed), 32'h7FFF);

        // rst and start together stay in IDLE
        start = 1'b1; n_cfg = 3'd5; prbs_len = 16'd7;
        tick(); tick();
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_det_n", 32'(det_n), 32'd0);
        rst = 1'b0;
        tick();

        // Basic run: n_cfg=3, len=5, detection 20 cycles after start
        clr_cnt();
        go(3'd3, 16'd5);
        check("arm_det_rst", 32'(det_rst), 32'd1);
        repeat (19) tick();
        pulse_det();
        wait_idle("basic_idle", 50);
        check("basic_en_cnt", 32'(en_cnt), 32'd5);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_load_cnt", 32'(load_cnt), 32'd1);
        check("basic_drst_cnt", 32'(drst_cnt), 32'd1);
        check("basic_det_n", 32'(det_n), 32'd3);
        check("basic_load_lat", 32'(load_cyc - m_cyc), 32'd1);
        check("basic_en_lat", 32'(first_en_cyc - m_cyc), 32'd2);
        check("basic_done_lat", 32'(done_cyc - m_cyc), 32'd7);

        // det_flag during ARM is ignored
        clr_cnt();
        go(3'd2, 16'd3);
        det_flag = 1'b1;
        tick();
        det_flag = 1'b0;
        repeat (3) tick();
        check("arm_flag_load", 32'(load_cnt), 32'd0);
        check("arm_flag_busy", 32'(busy), 32'd1);
        pulse_det();
        wait_idle("arm_flag_idle", 20);
        check("arm_flag_en_cnt", 32'(en_cnt), 32'd3);

        // Zero length: SEED then DONE
        clr_cnt();
        go(3'd1, 16'd0);
        repeat (3) tick();
        pulse_det();
        wait_idle("zero_idle", 20);
        check("zero_en_cnt", 32'(en_cnt), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);
        check("zero_done_lat", 32'(done_cyc - m_cyc), 32'd2);

        // Abort on the third RUN cycle
        clr_cnt();
        go(3'd4, 16'd10);
        repeat (2) tick();
        pulse_det();
        wait_en("abort_run_en", 10);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("abort_run_en_cnt", 32'(en_cnt), 32'd3);
        check("abort_run_done", 32'(done_cnt), 32'd0);

        // start during RUN ignored
        clr_cnt();
        go(3'd3, 16'd4);
        tick();
        pulse_det();
        wait_en("busy_start_en", 10);
        start = 1'b1; n_cfg = 3'd6; prbs_len = 16'd9;
        tick();
        start = 1'b0;
        check("busy_start_det_n", 32'(det_n), 32'd3);
        wait_idle("busy_start_idle", 20);
        check("busy_start_en_cnt", 32'(en_cnt), 32'd4);
        check("busy_start_done", 32'(done_cnt), 32'd1);

        // abort outranks det_flag in WAIT_DET
        clr_cnt();
        go(3'd2, 16'd2);
        tick();
        abort = 1'b1; det_flag = 1'b1;
        tick();
        abort = 1'b0; det_flag = 1'b0;
        check("abort_wait_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("abort_wait_load", 32'(load_cnt), 32'd0);

        // abort in ARM
        go(3'd1, 16'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_arm_busy", 32'(busy), 32'd0);

        // Reset in the middle of RUN
        clr_cnt();
        go(3'd5, 16'd8);
        tick();
        pulse_det();
        wait_en("rst_run_en", 10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_run_en", 32'(prbs_en), 32'd0);
        check("rst_run_det_n", 32'(det_n), 32'd0);
        repeat (3) tick();
        check("rst_run_done", 32'(done_cnt), 32'd0);

`ifdef PRBS_SEQ_CTRL_TIMEOUT_EN
        // Timeout: ERR after TMO WAIT_DET cycles, sticky flag, cleared by next start
        clr_cnt();
        go(3'd1, 16'd3);
        wait_idle("tmo_idle", int'(TMO) + 10);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_done", 32'(done_cnt), 32'd0);
        repeat (5) tick();
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        clr_cnt();
        go(3'd2, 16'd2);
        check("tmo_cleared", 32'(timeout_err), 32'd0);
        repeat (TMO) tick();
        pulse_det();
        wait_idle("tmo_edge_idle", 20);
        check("tmo_edge_err", 32'(timeout_err), 32'd0);
        check("tmo_edge_done", 32'(done_cnt), 32'd1);
        check("tmo_edge_en_cnt", 32'(en_cnt), 32'd2);
`else
        // No timeout: WAIT_DET holds indefinitely
        clr_cnt();
        go(3'd1, 16'd3);
        repeat (TMO * 3) tick();
        check("notmo_busy", 32'(busy), 32'd1);
        check("notmo_err", 32'(timeout_err), 32'd0);
        pulse_det();
        wait_idle("notmo_idle", 20);
        check("notmo_en_cnt", 32'(en_cnt), 32'd3);
        check("notmo_done", 32'(done_cnt), 32'd1);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
